mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline memory stage. Sits directly downstream of the execute stage's EX/MEM latch and consumes its outputs: control bits, ALU result, store data, destination register, PC+4 and opcode.
- Issues registered data-memory read/write requests to the dcache and waits for dhit.
- Stalls the upstream pipeline while an access is outstanding.
- Loads the MEM/WB pipeline register that feeds writeback.
- Also owns halt capture and a sticky memory-timeout flag.

Parameters:
- TIMEOUT, 64, REQ-state cycles without dhit before mem_err is set.
- CW, 7, width of the wait-cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX/MEM register holds a real instruction (0 = bubble).
- writeRegIN  in  1  register-write enable from EX/MEM.
- MemtoRegIN  in  1  writeback selects load data.
- dRENIN  in  1  instruction is a load.
- dWENIN  in  1  instruction is a store.
- RWDSelIN  in  2  writeback data-select code.
- opcodeIN  in  6  opcode_t.
- PCIncIN  in  32  PC+4.
- resultIN  in  32  ALU result, used as the data address.
- busBIN  in  32  store data.
- rwIN  in  5  destination register.
- haltIN  in  1  instruction is HALT.
- flush  in  1  replace the next MEM/WB load with a bubble.
- dhit  in  1  dcache completes the current request this cycle.
- dmemload  in  32  load data, valid when dhit=1.
- dmemREN  out  1  registered read request.
- dmemWEN  out  1  registered write request.
- dmemaddr  out  32  registered address.
- dmemstore  out  32  registered store data.
- mem_stall  out  1  upstream latches must hold; combinational.
- wb_valid  out  1  MEM/WB holds a real instruction.
- writeRegOUT  out  1  MEM/WB register-write enable.
- MemtoRegOUT  out  1  MEM/WB load-data select.
- RWDSelOUT  out  2  MEM/WB data-select code.
- opcodeOUT  out  6  MEM/WB opcode.
- rwOUT  out  5  MEM/WB destination register.
- resultOUT  out  32  MEM/WB ALU result.
- dloadOUT  out  32  MEM/WB load data.
- PCIncOUT  out  32  MEM/WB PC+4.
- haltOUT  out  1  MEM/WB halt.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (nRST=0, asynchronous): state=IDLE; all outputs 0; counter=0; flush_pend=0. Reset during REQ abandons the request immediately.
- Upstream contract: EX/MEM inputs stay stable while mem_stall=1.
- States: IDLE, REQ, HALT.
- IDLE, ex_valid=1 and haltIN=1:
  - MEM/WB loads the instruction with haltOUT=1 and wb_valid=1. No memory request is issued, even if dREN or dWEN is set.
  - Next state is HALT.
- IDLE, ex_valid=1 and (dRENIN|dWENIN):
  - mem_stall=1 this cycle.
  - On the clock edge: dmemREN<=dRENIN, dmemWEN<=dWENIN, dmemaddr<=resultIN, dmemstore<=busBIN, counter<=0, flush_pend<=flush.
  - MEM/WB is not loaded. Next state is REQ.
  - If both dRENIN and dWENIN are set, the write wins and dmemREN=0.
- IDLE, any other case (non-memory instruction or bubble):
  - mem_stall=0.
  - MEM/WB loads the inputs on the edge; wb_valid<=ex_valid&~flush.
  - A bubble or flush forces writeRegOUT=0 and haltOUT=0.
- REQ, dhit=0:
  - mem_stall=1; requests held; counter increments and saturates at 2^CW-1.
  - When counter reaches TIMEOUT-1, mem_err<=1. mem_err stays set until reset and the request stays held.
  - flush_pend<=flush_pend|flush.
- REQ, dhit=1:
  - mem_stall=0.
  - On the edge: MEM/WB loads, dloadOUT<=dmemload (load) or 0 (store), wb_valid<=~(flush_pend|flush).
  - dmemREN/dmemWEN<=0. Next state is IDLE.
  - A flush never cancels an issued access; it only bubbles the writeback.
  - Latency: a load accepted in cycle T with dhit in cycle T+k writes MEM/WB at the end of T+k. Minimum k=1, so a load takes 2 cycles.
- Back-to-back memory instructions: at least one IDLE cycle separates requests, so dmemREN/dmemWEN drop for ≥1 cycle between accesses.
- HALT: mem_stall=1; dmem requests 0; MEM/WB holds (haltOUT=1). Exit is by reset only.
- A dhit seen outside REQ is ignored.
- Widths: no arithmetic beyond the counter; addresses pass through unmodified.

Test Plan:
- Reset: nRST=0 asynchronously while in REQ with dmemREN=1 → dmemREN=0, mem_stall=0, state IDLE immediately without waiting for a clock edge; all outputs 0 after nRST=1.
- ALU op pass-through: ex_valid=1, writeRegIN=1, resultIN=0x0000_0010, rwIN=5, no memory op → after 1 edge: wb_valid=1, resultOUT=0x10, rwOUT=5; mem_stall=0 throughout.
- Load with wait: dRENIN=1, resultIN=0x0000_0100, dhit asserted on the 3rd REQ cycle with dmemload=0xDEAD_BEEF:
  - dmemaddr=0x100 and dmemREN=1 for exactly 3 cycles.
  - mem_stall=1 for 3 cycles.
  - dloadOUT=0xDEAD_BEEF, wb_valid=1.
- Store plus flush: dWENIN=1, busBIN=0x1234_5678, flush pulsed in the 1st REQ cycle, dhit on the 2nd → dmemWEN=1 with dmemstore=0x1234_5678 until dhit; wb_valid=0, writeRegOUT=0.
- Timeout: TIMEOUT=4, dRENIN=1, dhit held 0 → mem_err=1 after the 4th REQ cycle; mem_err stays 1 after a later dhit completes the load.
- Halt: ex_valid=1, haltIN=1, dRENIN=1 → haltOUT=1, dmemREN never asserted, mem_stall=1 on all later cycles until reset.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the dcache.
// Master drives registered REN/WEN/addr/store; slave returns dhit and load data.
interface mem_stage_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues dcache requests, stalls upstream while one is
// outstanding, loads MEM/WB, captures HALT and flags a sticky access timeout.
// Ports: CLK/nRST; EX/MEM inputs (*IN, ex_valid, flush); dbus (dcache master);
// MEM/WB outputs (*OUT, wb_valid); mem_stall and mem_err status.
module mem_stage #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic        writeRegIN,
    input  logic        MemtoRegIN,
    input  logic        dRENIN,
    input  logic        dWENIN,
    input  logic [1:0]  RWDSelIN,
    input  logic [5:0]  opcodeIN,
    input  logic [31:0] PCIncIN,
    input  logic [31:0] resultIN,
    input  logic [31:0] busBIN,
    input  logic [4:0]  rwIN,
    input  logic        haltIN,
    input  logic        flush,
    mem_stage_if.master dbus,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        writeRegOUT,
    output logic        MemtoRegOUT,
    output logic [1:0]  RWDSelOUT,
    output logic [5:0]  opcodeOUT,
    output logic [4:0]  rwOUT,
    output logic [31:0] resultOUT,
    output logic [31:0] dloadOUT,
    output logic [31:0] PCIncOUT,
    output logic        haltOUT,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        m2r;
        logic [1:0]  sel;
        logic [5:0]  op;
        logic [4:0]  rw;
        logic [31:0] res;
        logic [31:0] dload;
        logic [31:0] pc;
        logic        halt;
    } wb_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        fpend_q, fpend_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic        err_q, err_d;
    wb_t         wb_q, wb_d;
    logic        stall;
    logic        kill;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fpend_q <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            err_q   <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fpend_q <= fpend_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            err_q   <= err_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fpend_d = fpend_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        store_d = store_q;
        err_d   = err_q;
        wb_d    = wb_q;
        stall   = 1'b0;
        kill    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && haltIN) begin
                    // HALT retires without touching memory
                    wb_d.valid = 1'b1;
                    wb_d.wr    = writeRegIN;
                    wb_d.m2r   = MemtoRegIN;
                    wb_d.sel   = RWDSelIN;
                    wb_d.op    = opcodeIN;
                    wb_d.rw    = rwIN;
                    wb_d.res   = resultIN;
                    wb_d.dload = '0;
                    wb_d.pc    = PCIncIN;
                    wb_d.halt  = 1'b1;
                    state_d    = HALT;
                end else if (ex_valid && (dRENIN || dWENIN)) begin
                    stall   = 1'b1;
                    // a store takes precedence over a load
                    ren_d   = dRENIN & ~dWENIN;
                    wen_d   = dWENIN;
                    addr_d  = resultIN;
                    store_d = busBIN;
                    cnt_d   = '0;
                    fpend_d = flush;
                    state_d = REQ;
                end else begin
                    kill       = ~ex_valid | flush;
                    wb_d.valid = ~kill;
                    wb_d.wr    = writeRegIN & ~kill;
                    wb_d.m2r   = MemtoRegIN;
                    wb_d.sel   = RWDSelIN;
                    wb_d.op    = opcodeIN;
                    wb_d.rw    = rwIN;
                    wb_d.res   = resultIN;
                    wb_d.dload = '0;
                    wb_d.pc    = PCIncIN;
                    wb_d.halt  = 1'b0;
                end
            end
            REQ: begin
                if (dbus.dhit) begin
                    // flush only bubbles the writeback, never the access
                    kill       = fpend_q | flush;
                    wb_d.valid = ~kill;
                    wb_d.wr    = writeRegIN & ~kill;
                    wb_d.m2r   = MemtoRegIN;
                    wb_d.sel   = RWDSelIN;
                    wb_d.op    = opcodeIN;
                    wb_d.rw    = rwIN;
                    wb_d.res   = resultIN;
                    wb_d.dload = ren_q ? dbus.dmemload : 32'd0;
                    wb_d.pc    = PCIncIN;
                    wb_d.halt  = 1'b0;
                    ren_d      = 1'b0;
                    wen_d      = 1'b0;
                    state_d    = IDLE;
                end else begin
                    stall   = 1'b1;
                    fpend_d = fpend_q | flush;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_d = 1'b1;
                    end
                end
            end
            HALT: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // held low during reset so every output reads 0 while nRST=0
    assign mem_stall      = stall & nRST;

    assign dbus.dmemREN   = ren_q;
    assign dbus.dmemWEN   = wen_q;
    assign dbus.dmemaddr  = addr_q;
    assign dbus.dmemstore = store_q;

    assign wb_valid    = wb_q.valid;
    assign writeRegOUT = wb_q.wr;
    assign MemtoRegOUT = wb_q.m2r;
    assign RWDSelOUT   = wb_q.sel;
    assign opcodeOUT   = wb_q.op;
    assign rwOUT       = wb_q.rw;
    assign resultOUT   = wb_q.res;
    assign dloadOUT    = wb_q.dload;
    assign PCIncOUT    = wb_q.pc;
    assign haltOUT     = wb_q.halt;
    assign mem_err     = err_q;

endmodule
